// File: rtl/rv32_instr_encoder_if.sv
// Handshake bundle for the instruction encoder: packet input channel and encoded-word output channel.
interface rv32_instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [52:0] in_packet;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [5:0]  out_alu_op;

  modport master (
    output in_valid, in_packet, out_ready,
    input  in_ready, out_valid, out_instr, out_alu_op
  );

  modport slave (
    input  in_valid, in_packet, out_ready,
    output in_ready, out_valid, out_instr, out_alu_op
  );
endinterface

// File: rtl/rv32_instr_encoder.sv
// RV32IM instruction encoder: decoded packet in, 32-bit machine word out through a small FIFO.
package rv32_instr_encoder_pkg;
  typedef enum logic [5:0] {
    OP_ADD = 6'd0, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_NOP = 6'd63
  } alu_op_e;

  typedef struct packed {
    logic [5:0]  alu_op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm32;
  } rv32_instr_packet_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
endpackage

module rv32_instr_encoder
  import rv32_instr_encoder_pkg::*;
#(
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned ILL_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  rv32_instr_encoder_if.slave  bus,
  output logic                 err_illegal,
  output logic [31:0]          encoded_count,
  output logic [ILL_CNT_W-1:0] illegal_count
);
  localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned ENTRY_W = 38;

  typedef enum logic [3:0] {FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NOP, FMT_ILL} fmt_e;

  rv32_instr_packet_t   pkt;
  fmt_e                 fmt;
  logic [6:0]           opc, f7;
  logic [2:0]           f3;
  logic [31:0]          enc_word;
  logic                 legal;

  logic [ENTRY_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q, wr_n, rd_n;
  logic [CNT_W-1:0]     count_q, count_n;
  logic                 in_ready_q, out_valid_q;
  logic [ENTRY_W-1:0]   head_q, head_n;
  logic                 accept, push, pop;
  logic [31:0]          enc_cnt_n;
  logic [ILL_CNT_W-1:0] ill_cnt_n;

  assign pkt            = rv32_instr_packet_t'(bus.in_packet);
  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_instr  = head_q[31:0];
  assign bus.out_alu_op = head_q[37:32];

  // Per-op format, opcode, funct3 and funct7 selection.
  always_comb begin
    fmt = FMT_ILL;
    opc = 7'b0;
    f3  = 3'b000;
    f7  = 7'b0;
    case (pkt.alu_op)
      OP_ADD:    begin fmt = FMT_R;   opc = OPC_OP;     f3 = 3'b000; end
      OP_SUB:    begin fmt = FMT_R;   opc = OPC_OP;     f3 = 3'b000; f7 = 7'b0100000; end
      OP_SLL:    begin fmt = FMT_R;   opc = OPC_OP;     f3 = 3'b001; end
      OP_SLT:    begin fmt = FMT_R;   opc = OPC_OP;     f3 = 3'b010; end
      OP_SLTU:   begin fmt = FMT_R;   opc = OPC_OP;     f3 = 3'b011; end
      OP_XOR:    begin fmt = FMT_R;   opc = OPC_OP;     f3 = 3'b100; end
      OP_SRL:    begin fmt = FMT_R;   opc = OPC_OP;     f3 = 3'b101; end
      OP_SRA:    begin fmt = FMT_R;   opc = OPC_OP;     f3 = 3'b101; f7 = 7'b0100000; end
      OP_OR:     begin fmt = FMT_R;   opc = OPC_OP;     f3 = 3'b110; end
      OP_AND:    begin fmt = FMT_R;   opc = OPC_OP;     f3 = 3'b111; end
      OP_ADDI:   begin fmt = FMT_I;   opc = OPC_OPIMM;  f3 = 3'b000; end
      OP_SLTI:   begin fmt = FMT_I;   opc = OPC_OPIMM;  f3 = 3'b010; end
      OP_SLTIU:  begin fmt = FMT_I;   opc = OPC_OPIMM;  f3 = 3'b011; end
      OP_XORI:   begin fmt = FMT_I;   opc = OPC_OPIMM;  f3 = 3'b100; end
      OP_ORI:    begin fmt = FMT_I;   opc = OPC_OPIMM;  f3 = 3'b110; end
      OP_ANDI:   begin fmt = FMT_I;   opc = OPC_OPIMM;  f3 = 3'b111; end
      OP_SLLI:   begin fmt = FMT_SH;  opc = OPC_OPIMM;  f3 = 3'b001; end
      OP_SRLI:   begin fmt = FMT_SH;  opc = OPC_OPIMM;  f3 = 3'b101; end
      OP_SRAI:   begin fmt = FMT_SH;  opc = OPC_OPIMM;  f3 = 3'b101; f7 = 7'b0100000; end
      OP_LB:     begin fmt = FMT_I;   opc = OPC_LOAD;   f3 = 3'b000; end
      OP_LH:     begin fmt = FMT_I;   opc = OPC_LOAD;   f3 = 3'b001; end
      OP_LW:     begin fmt = FMT_I;   opc = OPC_LOAD;   f3 = 3'b010; end
      OP_LBU:    begin fmt = FMT_I;   opc = OPC_LOAD;   f3 = 3'b100; end
      OP_LHU:    begin fmt = FMT_I;   opc = OPC_LOAD;   f3 = 3'b101; end
      OP_SB:     begin fmt = FMT_S;   opc = OPC_STORE;  f3 = 3'b000; end
      OP_SH:     begin fmt = FMT_S;   opc = OPC_STORE;  f3 = 3'b001; end
      OP_SW:     begin fmt = FMT_S;   opc = OPC_STORE;  f3 = 3'b010; end
      OP_BEQ:    begin fmt = FMT_B;   opc = OPC_BRANCH; f3 = 3'b000; end
      OP_BNE:    begin fmt = FMT_B;   opc = OPC_BRANCH; f3 = 3'b001; end
      OP_BLT:    begin fmt = FMT_B;   opc = OPC_BRANCH; f3 = 3'b100; end
      OP_BGE:    begin fmt = FMT_B;   opc = OPC_BRANCH; f3 = 3'b101; end
      OP_BLTU:   begin fmt = FMT_B;   opc = OPC_BRANCH; f3 = 3'b110; end
      OP_BGEU:   begin fmt = FMT_B;   opc = OPC_BRANCH; f3 = 3'b111; end
      OP_JAL:    begin fmt = FMT_J;   opc = OPC_JAL;    end
      OP_JALR:   begin fmt = FMT_I;   opc = OPC_JALR;   f3 = 3'b000; end
      OP_LUI:    begin fmt = FMT_U;   opc = OPC_LUI;    end
      OP_AUIPC:  begin fmt = FMT_U;   opc = OPC_AUIPC;  end
      OP_MUL:    begin fmt = FMT_R;   opc = OPC_OP;     f3 = 3'b000; f7 = 7'b0000001; end
      OP_MULH:   begin fmt = FMT_R;   opc = OPC_OP;     f3 = 3'b001; f7 = 7'b0000001; end
      OP_MULHSU: begin fmt = FMT_R;   opc = OPC_OP;     f3 = 3'b010; f7 = 7'b0000001; end
      OP_MULHU:  begin fmt = FMT_R;   opc = OPC_OP;     f3 = 3'b011; f7 = 7'b0000001; end
      OP_DIV:    begin fmt = FMT_R;   opc = OPC_OP;     f3 = 3'b100; f7 = 7'b0000001; end
      OP_DIVU:   begin fmt = FMT_R;   opc = OPC_OP;     f3 = 3'b101; f7 = 7'b0000001; end
      OP_REM:    begin fmt = FMT_R;   opc = OPC_OP;     f3 = 3'b110; f7 = 7'b0000001; end
      OP_REMU:   begin fmt = FMT_R;   opc = OPC_OP;     f3 = 3'b111; f7 = 7'b0000001; end
      OP_NOP:    begin fmt = FMT_NOP; end
      default:   begin fmt = FMT_ILL; end
    endcase
  end

  // Field packing for the selected format; immediates are silently truncated.
  always_comb begin
    enc_word = 32'h0;
    case (fmt)
      FMT_R:   enc_word = {f7, pkt.rs2, pkt.rs1, f3, pkt.rd, opc};
      FMT_I:   enc_word = {pkt.imm32[11:0], pkt.rs1, f3, pkt.rd, opc};
      FMT_SH:  enc_word = {f7, pkt.imm32[4:0], pkt.rs1, f3, pkt.rd, opc};
      FMT_S:   enc_word = {pkt.imm32[11:5], pkt.rs2, pkt.rs1, f3, pkt.imm32[4:0], opc};
      FMT_B:   enc_word = {pkt.imm32[12], pkt.imm32[10:5], pkt.rs2, pkt.rs1, f3,
                           pkt.imm32[4:1], pkt.imm32[11], opc};
      FMT_U:   enc_word = {pkt.imm32[31:12], pkt.rd, opc};
      FMT_J:   enc_word = {pkt.imm32[20], pkt.imm32[10:1], pkt.imm32[11], pkt.imm32[19:12],
                           pkt.rd, opc};
      FMT_NOP: enc_word = 32'h0000_0013;
      default: enc_word = 32'h0;
    endcase
  end

  assign legal = (fmt != FMT_ILL);

  // Next-state for FIFO pointers, occupancy, registered head and counters.
  always_comb begin
    accept    = bus.in_valid && in_ready_q && !flush_i;
    push      = accept && legal;
    pop       = out_valid_q && bus.out_ready && !flush_i;
    wr_n      = wr_ptr_q;
    rd_n      = rd_ptr_q;
    count_n   = count_q;
    head_n    = head_q;
    enc_cnt_n = encoded_count;
    ill_cnt_n = illegal_count;
    if (flush_i) begin
      wr_n    = '0;
      rd_n    = '0;
      count_n = '0;
    end else begin
      if (push) wr_n = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_n = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_n = count_q + CNT_W'(1);
      else if (!push && pop) count_n = count_q - CNT_W'(1);
    end
    // A word written this edge at the new head slot must bypass the array.
    if (count_n != '0) begin
      head_n = (push && (wr_ptr_q == rd_n)) ? {pkt.alu_op, enc_word} : mem[rd_n];
    end
    if (push) enc_cnt_n = encoded_count + 32'd1;
    if (accept && !legal && (illegal_count != {ILL_CNT_W{1'b1}})) begin
      ill_cnt_n = illegal_count + ILL_CNT_W'(1);
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      head_q        <= '0;
      err_illegal   <= 1'b0;
      encoded_count <= 32'd0;
      illegal_count <= '0;
    end else begin
      wr_ptr_q      <= wr_n;
      rd_ptr_q      <= rd_n;
      count_q       <= count_n;
      in_ready_q    <= (count_n < CNT_W'(DEPTH));
      out_valid_q   <= (count_n != '0);
      head_q        <= head_n;
      err_illegal   <= accept && !legal;
      encoded_count <= enc_cnt_n;
      illegal_count <= ill_cnt_n;
    end
  end

  // FIFO storage; contents are invalidated by pointer reset, not cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {pkt.alu_op, enc_word};
  end
endmodule

// File: tb/tb_rv32_instr_encoder.sv
// Randomized bench for rv32_instr_encoder against a queue-based reference model.
module tb_rv32_instr_encoder;
  import rv32_instr_encoder_pkg::*;

  localparam int unsigned DEPTH     = 2;
  localparam int unsigned ILL_CNT_W = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush_i;
  logic                 err_illegal;
  logic [31:0]          encoded_count;
  logic [ILL_CNT_W-1:0] illegal_count;

  rv32_instr_encoder_if bus();

  rv32_instr_encoder #(.DEPTH(DEPTH), .ILL_CNT_W(ILL_CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush_i),
    .bus           (bus),
    .err_illegal   (err_illegal),
    .encoded_count (encoded_count),
    .illegal_count (illegal_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference tables indexed by position inside each instruction group.
  int unsigned r_f3 [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
  int unsigned r_f7 [10] = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};
  int unsigned i_f3 [6]  = '{0, 2, 3, 4, 6, 7};
  int unsigned l_f3 [5]  = '{0, 1, 2, 4, 5};
  int unsigned b_f3 [6]  = '{0, 1, 4, 5, 6, 7};

  // Model state.
  logic [37:0]          q[$];
  bit                   m_in_ready;
  bit                   m_err;
  logic [31:0]          m_enc;
  logic [ILL_CNT_W-1:0] m_ill;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Returns {legal, word} from the RV32IM field rules.
  function automatic logic [32:0] ref_encode(input logic [52:0] p);
    rv32_instr_packet_t pk;
    int unsigned op, rd, rs1, rs2, im, w;
    bit ok;
    pk  = p;
    op  = pk.alu_op;
    rd  = pk.rd;
    rs1 = pk.rs1;
    rs2 = pk.rs2;
    im  = pk.imm32;
    w   = 0;
    ok  = 1;
    if (op <= 9)
      w = (r_f7[op] << 25) | (rs2 << 20) | (rs1 << 15) | (r_f3[op] << 12) | (rd << 7) | 'h33;
    else if (op >= 37 && op <= 44)
      w = (1 << 25) | (rs2 << 20) | (rs1 << 15) | ((op - 37) << 12) | (rd << 7) | 'h33;
    else if (op <= 15)
      w = ((im % 4096) << 20) | (rs1 << 15) | (i_f3[op - 10] << 12) | (rd << 7) | 'h13;
    else if (op <= 18)
      w = ((op == 18 ? 32 : 0) << 25) | ((im % 32) << 20) | (rs1 << 15)
        | ((op == 16 ? 1 : 5) << 12) | (rd << 7) | 'h13;
    else if (op <= 23)
      w = ((im % 4096) << 20) | (rs1 << 15) | (l_f3[op - 19] << 12) | (rd << 7) | 'h03;
    else if (op <= 26)
      w = (((im >> 5) % 128) << 25) | (rs2 << 20) | (rs1 << 15) | ((op - 24) << 12)
        | ((im % 32) << 7) | 'h23;
    else if (op <= 32)
      w = (((im >> 12) & 1) << 31) | (((im >> 5) & 63) << 25) | (rs2 << 20) | (rs1 << 15)
        | (b_f3[op - 27] << 12) | (((im >> 1) & 15) << 8) | (((im >> 11) & 1) << 7) | 'h63;
    else if (op == 33)
      w = (((im >> 20) & 1) << 31) | (((im >> 1) & 1023) << 21) | (((im >> 11) & 1) << 20)
        | (((im >> 12) & 255) << 12) | (rd << 7) | 'h6F;
    else if (op == 34)
      w = ((im % 4096) << 20) | (rs1 << 15) | (rd << 7) | 'h67;
    else if (op == 35 || op == 36)
      w = (im & 32'hFFFF_F000) | (rd << 7) | (op == 35 ? 'h37 : 'h17);
    else if (op == 63)
      w = 'h13;
    else
      ok = 0;
    return {ok, w[31:0]};
  endfunction

  // Advance model and DUT one cycle using the currently driven inputs, then compare.
  task automatic step();
    logic [32:0] e;
    rv32_instr_packet_t p;
    bit acc, pop;
    p   = bus.in_packet;
    e   = ref_encode(bus.in_packet);
    acc = bus.in_valid && m_in_ready && !flush_i;
    pop = (q.size() > 0) && bus.out_ready && !flush_i;
    if (rst) begin
      q.delete();
      m_in_ready = 1;
      m_err      = 0;
      m_enc      = 0;
      m_ill      = 0;
    end else begin
      if (flush_i) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (acc && e[32]) q.push_back({p.alu_op, e[31:0]});
      end
      m_err = acc && !e[32];
      if (acc && e[32]) m_enc = m_enc + 32'd1;
      if (acc && !e[32] && m_ill != {ILL_CNT_W{1'b1}}) m_ill = m_ill + 1'b1;
      m_in_ready = q.size() < DEPTH;
    end
    @(posedge clk);
    @(negedge clk);
    check_eq("in_ready", bus.in_ready, m_in_ready);
    check_eq("out_valid", bus.out_valid, q.size() > 0);
    check_eq("err_illegal", err_illegal, m_err);
    check_eq("encoded_count", encoded_count, m_enc);
    check_eq("illegal_count", illegal_count, m_ill);
    if (q.size() > 0) begin
      check_eq("out_instr", bus.out_instr, q[0][31:0]);
      check_eq("out_alu_op", bus.out_alu_op, q[0][37:32]);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    rv32_instr_packet_t p;
    p.alu_op = op;
    p.rd     = rd;
    p.rs1    = rs1;
    p.rs2    = rs2;
    p.imm32  = imm;
    bus.in_valid  = v;
    bus.in_packet = p;
  endtask

  task automatic drive_rand_legal();
    logic [5:0] op;
    op = 6'($urandom_range(0, 44));
    drive(1'b1, op, 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
  endtask

  // Directed vectors with hand-derived machine words.
  logic [5:0]  v_op  [8] = '{6'd0, 6'd1, 6'd37, 6'd10, 6'd26, 6'd63, 6'd27, 6'd33};
  logic [4:0]  v_rd  [8] = '{5'd1, 5'd5, 5'd10, 5'd1, 5'd0, 5'd7, 5'd0, 5'd1};
  logic [4:0]  v_rs1 [8] = '{5'd2, 5'd6, 5'd11, 5'd0, 5'd1, 5'd3, 5'd1, 5'd0};
  logic [4:0]  v_rs2 [8] = '{5'd3, 5'd7, 5'd12, 5'd0, 5'd2, 5'd9, 5'd2, 5'd0};
  logic [31:0] v_imm [8] = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd8, 32'd12345,
                             32'hFFFF_FFFC, 32'h0000_0800};
  logic [31:0] v_exp [8] = '{32'h003100B3, 32'h407302B3, 32'h02C58533, 32'hFFF00093,
                             32'h0020A423, 32'h00000013, 32'hFE208EE3, 32'h001000EF};

  initial begin
    rst           = 1'b1;
    flush_i       = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    step();
    step();
    check_eq("reset_out_instr", bus.out_instr, 32'h0);
    check_eq("reset_out_alu_op", bus.out_alu_op, 6'h0);
    rst = 1'b0;

    // Back-to-back directed words, one per cycle.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, v_op[i], v_rd[i], v_rs1[i], v_rs2[i], v_imm[i]);
      step();
      check_eq($sformatf("vec%0d_word", i), bus.out_instr, v_exp[i]);
    end
    drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    step();
    check_eq("vec_encoded_count", encoded_count, 32'd8);

    // Backpressure: three packets into a two-entry FIFO.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_rand_legal();
      step();
    end
    check_eq("bp_full_in_ready", bus.in_ready, 1'b0);
    bus.out_ready = 1'b1;
    step();
    check_eq("bp_release_in_ready", bus.in_ready, 1'b1);
    drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    for (int i = 0; i < 4; i++) step();

    // Illegal op: consumed, not enqueued, one-cycle error pulse.
    drive(1'b1, 6'd45, 5'd1, 5'd2, 5'd3, 32'd4);
    step();
    check_eq("ill_pulse", err_illegal, 1'b1);
    check_eq("ill_no_valid", bus.out_valid, 1'b0);
    drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    step();
    check_eq("ill_pulse_end", err_illegal, 1'b0);

    // Flush with a full FIFO and a simultaneous valid input.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_rand_legal();
      step();
    end
    flush_i = 1'b1;
    drive_rand_legal();
    step();
    check_eq("flush_out_valid", bus.out_valid, 1'b0);
    check_eq("flush_in_ready", bus.in_ready, 1'b1);
    flush_i = 1'b0;
    drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    step();

    // Reset mid-stream, with an illegal packet presented on the same edge.
    drive_rand_legal();
    step();
    drive(1'b1, 6'd50, 5'd0, 5'd0, 5'd0, 32'd0);
    rst = 1'b1;
    step();
    check_eq("rst_out_instr", bus.out_instr, 32'h0);
    check_eq("rst_err", err_illegal, 1'b0);
    rst = 1'b0;
    drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    step();

    // Random traffic across all ops including illegal ones.
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 3) != 0, 6'($urandom), 5'($urandom), 5'($urandom),
            5'($urandom), $urandom);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      flush_i       = ($urandom_range(0, 31) == 0);
      rst           = ($urandom_range(0, 255) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
